// File: rtl/pipe_trace_tracker_if.sv
// rtl/pipe_trace_tracker_if.sv - retire stream bundle between the trace tracker and its checker
//
// Signals:
//   ret_valid   head record available (tracker drives)
//   ret_ready   checker accepts the head record (checker drives)
//   ret_instr   head instruction word
//   ret_fields  head record fields, field f at [XLEN*f +: XLEN]
// Modports: master = tracker side, slave = checker side.
interface pipe_trace_tracker_if #(
    parameter int XLEN       = 32,
    parameter int NUM_FIELDS = 6
);
    logic                       ret_valid;
    logic                       ret_ready;
    logic [XLEN-1:0]            ret_instr;
    logic [NUM_FIELDS*XLEN-1:0] ret_fields;

    modport master (
        output ret_valid,
        output ret_instr,
        output ret_fields,
        input  ret_ready
    );

    modport slave (
        input  ret_valid,
        input  ret_instr,
        input  ret_fields,
        output ret_ready
    );
endinterface

// File: rtl/pipe_trace_tracker.sv
// rtl/pipe_trace_tracker.sv - shadow pipeline that follows each fetched instruction and retires records to a FIFO
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_instr/in_pc  fetch-side record load into slot 0 (pc lands in field 3)
//   stall, flush        freeze all slots; kill the FLUSH_STAGES youngest slots
//   cap_en/cap_sel/cap_data  per-slot field capture (slot i: sel [3i+2:3i], data [XLEN*i +: XLEN])
//   ret                 retire stream (pipe_trace_tracker_if.master), show-ahead FIFO head
//   overflow            sticky: a retiring record was dropped because the FIFO was full
//   occupancy           number of records held in the retire FIFO
// Optional build macro: RETIRE_CNT_EN adds retire_cnt (records successfully pushed since reset).
module pipe_trace_tracker #(
    parameter int XLEN         = 32,
    parameter int STAGES       = 5,
    parameter int NUM_FIELDS   = 6,
    parameter int FLUSH_STAGES = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [XLEN-1:0]             in_instr,
    input  logic [XLEN-1:0]             in_pc,
    input  logic                        stall,
    input  logic                        flush,
    input  logic [STAGES-1:0]           cap_en,
    input  logic [STAGES*3-1:0]         cap_sel,
    input  logic [STAGES*XLEN-1:0]      cap_data,
    pipe_trace_tracker_if.master        ret,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] occupancy
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0]                 retire_cnt
`endif
);
    localparam int RW = NUM_FIELDS * XLEN;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [STAGES-1:0] slot_valid;
    logic [XLEN-1:0]   slot_instr  [STAGES];
    logic [RW-1:0]     slot_fields [STAGES];

    // Slot fields with this cycle's capture applied; used both for in-place
    // update under stall and for the record as it moves to the next slot.
    logic [RW-1:0]     cap_fields  [STAGES];
    logic [RW-1:0]     new_fields;

    logic [XLEN-1:0]   fifo_instr  [FIFO_DEPTH];
    logic [RW-1:0]     fifo_fields [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic push;
    logic pop;
    logic full;
    logic push_ok;

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            cap_fields[i] = slot_fields[i];
            if (slot_valid[i] && cap_en[i]) begin
                // Out-of-range selects match no field and are thereby ignored.
                for (int f = 0; f < NUM_FIELDS; f++) begin
                    if (int'(cap_sel[3*i +: 3]) == f) begin
                        cap_fields[i][XLEN*f +: XLEN] = cap_data[XLEN*i +: XLEN];
                    end
                end
            end
        end
    end

    always_comb begin
        new_fields = '0;
        new_fields[XLEN*3 +: XLEN] = in_pc;
    end

    // The oldest slot is never in the flush range, so only stall gates retirement.
    assign push    = !stall && slot_valid[STAGES-1];
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop     = (count != '0) && ret.ret_ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                slot_instr[i]  <= '0;
                slot_fields[i] <= '0;
            end
        end else begin
            // Flush redirects fetch, so slot 0 loads even while stalled.
            if (!stall || flush) begin
                slot_valid[0]  <= in_valid;
                slot_instr[0]  <= in_instr;
                slot_fields[0] <= new_fields;
            end else begin
                slot_fields[0] <= cap_fields[0];
            end
            for (int i = 1; i < STAGES; i++) begin
                if (!stall) begin
                    slot_valid[i]  <= slot_valid[i-1] && !(flush && (i - 1) < FLUSH_STAGES);
                    slot_instr[i]  <= slot_instr[i-1];
                    slot_fields[i] <= cap_fields[i-1];
                end else if (flush && i < FLUSH_STAGES) begin
                    slot_valid[i]  <= 1'b0;
                end else begin
                    slot_fields[i] <= cap_fields[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                fifo_instr[j]  <= '0;
                fifo_fields[j] <= '0;
            end
        end else begin
            if (push_ok) begin
                fifo_instr[wr_ptr]  <= slot_instr[STAGES-1];
                fifo_fields[wr_ptr] <= cap_fields[STAGES-1];
                wr_ptr              <= wr_ptr + AW'(1);
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

`ifdef RETIRE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (push_ok) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

    // Storage is reset, so the head reads zero after reset without a reset mux.
    assign ret.ret_valid  = (count != '0);
    assign ret.ret_instr  = fifo_instr[rd_ptr];
    assign ret.ret_fields = fifo_fields[rd_ptr];
    assign occupancy      = count;
endmodule

// File: tb/tb_pipe_trace_tracker.sv
// tb/tb_pipe_trace_tracker.sv - directed self-checking bench for pipe_trace_tracker
module tb_pipe_trace_tracker;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [31:0]  in_instr = '0;
    logic [31:0]  in_pc = '0;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic [4:0]   cap_en = '0;
    logic [14:0]  cap_sel = '0;
    logic [159:0] cap_data = '0;
    logic         overflow;
    logic [2:0]   occupancy;
`ifdef RETIRE_CNT_EN
    logic [31:0]  retire_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_trace_tracker_if #(.XLEN(32), .NUM_FIELDS(6)) bus ();

    pipe_trace_tracker #(
        .XLEN(32), .STAGES(5), .NUM_FIELDS(6), .FLUSH_STAGES(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_instr(in_instr),
        .in_pc(in_pc),
        .stall(stall),
        .flush(flush),
        .cap_en(cap_en),
        .cap_sel(cap_sel),
        .cap_data(cap_data),
        .ret(bus),
        .overflow(overflow),
        .occupancy(occupancy)
`ifdef RETIRE_CNT_EN
        ,
        .retire_cnt(retire_cnt)
`endif
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick(1);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] fld(input int f);
        return bus.ret_fields[32*f +: 32];
    endfunction

    initial begin
        bus.ret_ready = 1'b0;

        // Reset state
        tick(1);
        chk("rst_valid", 64'(bus.ret_valid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_instr", 64'(bus.ret_instr), 64'd0);
        rst = 1'b0;

        // Mid-stream async reset: 3 queued, 3 in flight
        for (int k = 0; k < 6; k++) load(32'h0000_0A00 + 32'(k), 32'(4 * k));
        tick(2);
        chk("pre_rst_occ", 64'(occupancy), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(bus.ret_valid), 64'd0);
        chk("async_rst_occ", 64'(occupancy), 64'd0);
        chk("async_rst_instr", 64'(bus.ret_instr), 64'd0);
        chk("async_rst_ovf", 64'(overflow), 64'd0);
        #1 rst = 1'b0;
        tick(8);
        chk("post_rst_occ", 64'(occupancy), 64'd0);
        chk("post_rst_valid", 64'(bus.ret_valid), 64'd0);

        // Straight flow: 5-edge latency
        bus.ret_ready = 1'b1;
        load(32'h0050_0093, 32'h0);
        tick(4);
        chk("flow_early", 64'(bus.ret_valid), 64'd0);
        tick(1);
        chk("flow_valid", 64'(bus.ret_valid), 64'd1);
        chk("flow_instr", 64'(bus.ret_instr), 64'h0050_0093);
        chk("flow_pc", 64'(fld(3)), 64'h0);
        tick(1);
        chk("flow_popped", 64'(bus.ret_valid), 64'd0);

        // Capture on slot 3 into field 0
        load(32'h00A0_0113, 32'h4);
        tick(3);
        cap_en = 5'b01000; cap_sel[11:9] = 3'd0; cap_data[127:96] = 32'h5;
        tick(1);
        cap_en = '0;
        tick(1);
        chk("cap_valid", 64'(bus.ret_valid), 64'd1);
        chk("cap_f0", 64'(fld(0)), 64'h5);
        chk("cap_f3", 64'(fld(3)), 64'h4);
        tick(1);

        // Capture slot 1 field 2, then out-of-range select on slot 3
        load(32'h00C0_0193, 32'h8);
        tick(1);
        cap_en = 5'b00010; cap_sel[5:3] = 3'd2; cap_data[63:32] = 32'h77;
        tick(1);
        cap_en = '0;
        tick(1);
        cap_en = 5'b01000; cap_sel[11:9] = 3'd7; cap_data[127:96] = 32'h99;
        tick(1);
        cap_en = '0;
        tick(1);
        chk("sel7_instr", 64'(bus.ret_instr), 64'h00C0_0193);
        chk("sel7_f0", 64'(fld(0)), 64'h0);
        chk("sel7_f2", 64'(fld(2)), 64'h77);
        chk("sel7_f3", 64'(fld(3)), 64'h8);
        chk("sel7_f5", 64'(fld(5)), 64'h0);
        tick(1);

        // Two-cycle stall delays retirement by two edges
        load(32'h11, 32'h10);
        tick(2);
        stall = 1'b1;
        tick(2);
        stall = 1'b0;
        tick(2);
        chk("stall_early", 64'(bus.ret_valid), 64'd0);
        tick(1);
        chk("stall_valid", 64'(bus.ret_valid), 64'd1);
        chk("stall_instr", 64'(bus.ret_instr), 64'h11);
        tick(1);

        // Flush kills slots 0 and 1; redirect target retires
        load(32'h21, 32'h20);
        load(32'h22, 32'h24);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h23; in_pc = 32'h40;
        tick(1);
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("flush_occ", 64'(occupancy), 64'd0);
        end
        tick(1);
        chk("flush_valid", 64'(bus.ret_valid), 64'd1);
        chk("flush_instr", 64'(bus.ret_instr), 64'h23);
        chk("flush_pc", 64'(fld(3)), 64'h40);
        tick(1);

        // Backpressure: 6 records into depth 4
        bus.ret_ready = 1'b0;
        for (int k = 0; k < 6; k++) load(32'h100 + 32'(k), 32'(4 * k));
        tick(5);
        chk("bp_occ", 64'(occupancy), 64'd4);
        chk("bp_ovf", 64'(overflow), 64'd1);
        chk("bp_valid", 64'(bus.ret_valid), 64'd1);
        bus.ret_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_order", 64'(bus.ret_instr), 64'h100 + 64'(k));
            tick(1);
        end
        chk("bp_drained", 64'(occupancy), 64'd0);

        // Reset clears sticky overflow
        bus.ret_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("ovf_cleared", 64'(overflow), 64'd0);
        rst = 1'b0;

        // Push and pop together while full
        for (int k = 0; k < 4; k++) load(32'h200 + 32'(k), 32'h0);
        tick(1);
        load(32'h204, 32'h0);
        tick(3);
        chk("full_occ", 64'(occupancy), 64'd4);
        chk("full_ovf", 64'(overflow), 64'd0);
        tick(1);
        bus.ret_ready = 1'b1;
        tick(1);
        chk("pp_occ", 64'(occupancy), 64'd4);
        chk("pp_ovf", 64'(overflow), 64'd0);
        chk("pp_head", 64'(bus.ret_instr), 64'h201);
        tick(3);
        chk("pp_last", 64'(bus.ret_instr), 64'h204);
        chk("pp_last_occ", 64'(occupancy), 64'd1);
        tick(1);
        chk("pp_empty", 64'(occupancy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
